pr_free_list: RTL
=================

Name: pr_free_list

Overview:
- Physical-register allocator that sits directly upstream of the physical register file.
- Keeps a circular FIFO of free PRs and grants up to NUM_SICS allocations per cycle to the Issue Controller.
- Grant outputs drive the register file's alloc_wen/alloc_pr directly.
- Released PRs wait in quarantine until the register file's pr_not_idle bit for that PR is 0, then return to the FIFO.

Parameters:
NUM_PHY_REGS, 64, total PRs; must be > NUM_ARCH_REGS.
NUM_SICS, 2, number of allocation ports.
NUM_ARCH_REGS, 32, PRs 0..NUM_ARCH_REGS-1 are reserved and never allocated or reclaimed.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
alloc_req  in  [NUM_SICS]x1  port s requests one new PR this cycle.
alloc_gnt  out  [NUM_SICS]x1  combinational grant; wires to RF alloc_wen.
alloc_pr  out  [NUM_SICS]x$clog2(NUM_PHY_REGS)  granted PR, valid when alloc_gnt[s]=1, else 0; wires to RF alloc_pr.
rel_valid  in  1  release one PR (old mapping retired).
rel_pr  in  $clog2(NUM_PHY_REGS)  PR being released.
pr_not_idle  in  NUM_PHY_REGS  usage bitmap from the register file.
free_count  out  $clog2(NUM_PHY_REGS)+1  registered FIFO occupancy.
empty  out  1  free_count==0.

Behaviour:
- Storage:
  - FIFO depth D = NUM_PHY_REGS-NUM_ARCH_REGS, with head pointer, tail pointer and count; pointers wrap modulo D.
  - Quarantine bitmap pending[NUM_PHY_REGS].
- Reset (rst=1 at posedge):
  - FIFO holds NUM_ARCH_REGS..NUM_PHY_REGS-1 ascending from entry 0; head=0, tail=0 (full), count=D.
  - pending=0.
  - While rst=1, alloc_gnt=0 and alloc_pr=0 regardless of alloc_req.
  - Reset mid-operation discards all pending releases and all grants in flight.
- Grant (combinational, same cycle as request):
  - k(s) = number of ports j<s with alloc_req[j]=1.
  - alloc_gnt[s] = alloc_req[s] && k(s) < count.
  - alloc_pr[s] = fifo[(head+k(s)) mod D].
  - Lower port index has priority; a denied port receives nothing and must re-request next cycle.
- Pop: at posedge, head advances by the number of grants and count decreases by the same number.
- Release: at posedge with rel_valid=1:
  - rel_pr < NUM_ARCH_REGS is ignored.
  - Otherwise pending[rel_pr] is set.
- Reclaim (at most one per cycle):
  - Candidate c = lowest index with pending[c]=1 && pr_not_idle[c]=0.
  - If a candidate exists: fifo[tail] <= c, tail advances, count increments, pending[c] clears.
  - A PR released this cycle is not a candidate until the next cycle (pending is registered).
- Simultaneous pop and push: count_next = count - grants + push. A pushed PR is grantable no earlier than the next cycle.
- Count never exceeds D. Each PR is in exactly one of: FIFO, pending, allocated.
- free_count and empty reflect registered count (pre-update in the current cycle).

Optional Feature:
- Macro: PR_FREE_LIST_BYPASS_EN.
- Defined: when count==0, a reclaim candidate c exists and some port requests, the lowest requesting port is granted c in the same cycle. pending[c] clears, no FIFO push, count unchanged. Only one bypass per cycle.
- Undefined: no bypass; with count==0 all grants are 0 and c is pushed normally.

Test Plan:
- Reset, NUM_PHY_REGS=64, NUM_SICS=2 -> free_count=32, empty=0. alloc_req={1,1} -> gnt={1,1}, alloc_pr={32,33}; next cycle free_count=30.
- alloc_req={0,1} -> only port1 granted, alloc_pr[1]=34, alloc_pr[0]=0. Then allocate until count=1 and assert alloc_req={1,1} -> gnt={1,0}, alloc_pr[0]=63; next cycle empty=1.
- Release rel_pr=40 with pr_not_idle[40]=1 held 5 cycles -> free_count unchanged. Drop bit 40 -> one cycle later free_count+1, and the next grant after older entries returns 40.
- Same cycle: two grants plus a reclaim push with count=10 -> free_count=9 next cycle. rel_pr=5 -> ignored, free_count unchanged.
- Releases of 50 and 45 both idle -> 45 pushed first, 50 the cycle after. rst asserted mid-stream -> next cycle free_count=32, first grant 32, pending cleared.
- PR_FREE_LIST_BYPASS_EN defined, empty, pending 48 idle, alloc_req={1,0} -> same-cycle gnt[0]=1, alloc_pr=48, free_count stays 0. Undefined -> gnt=0, free_count=1 next cycle.

Source files
------------

// File: rtl/pr_free_list.sv
// pr_free_list: circular free list of physical registers with release quarantine.
// Optional same-cycle bypass of a reclaimed PR when empty: PR_FREE_LIST_BYPASS_EN.
module pr_free_list #(
  parameter int NUM_PHY_REGS  = 64,
  parameter int NUM_SICS      = 2,
  parameter int NUM_ARCH_REGS = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_SICS-1:0]                         alloc_req,
  output logic [NUM_SICS-1:0]                         alloc_gnt,
  output logic [NUM_SICS-1:0][$clog2(NUM_PHY_REGS)-1:0] alloc_pr,
  input  logic                                        rel_valid,
  input  logic [$clog2(NUM_PHY_REGS)-1:0]             rel_pr,
  input  logic [NUM_PHY_REGS-1:0]                     pr_not_idle,
  output logic [$clog2(NUM_PHY_REGS):0]               free_count,
  output logic                                        empty
);

  localparam int PW = $clog2(NUM_PHY_REGS);
  localparam int CW = PW + 1;
  localparam int D  = NUM_PHY_REGS - NUM_ARCH_REGS;
  localparam int AW = (D > 1) ? $clog2(D) : 1;

  localparam logic [CW-1:0] DEPTH = CW'(D);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [PW-1:0] ARCH  = PW'(NUM_ARCH_REGS);

  logic [PW-1:0]           fifo_q [D];
  logic [AW-1:0]           head_q, head_d;
  logic [AW-1:0]           tail_q, tail_d;
  logic [CW-1:0]           count_q, count_d;
  logic [NUM_PHY_REGS-1:0] pend_q, pend_d;

  logic          cand_vld;
  logic [PW-1:0] cand;
  logic [CW-1:0] k;
  logic [CW-1:0] ngnt;
  logic          push;
`ifdef PR_FREE_LIST_BYPASS_EN
  logic          byp;
`endif

  // Both sums stay below 2*D, so one conditional subtract wraps them.
  function automatic logic [AW-1:0] wrap(input logic [CW-1:0] v);
    if (v >= DEPTH) return AW'(v - DEPTH);
    return AW'(v);
  endfunction

  assign free_count = count_q;
  assign empty      = (count_q == '0);

  // Lowest-index quarantined PR whose register-file usage has drained.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    for (int i = NUM_PHY_REGS - 1; i >= 0; i--) begin
      if (pend_q[i] && !pr_not_idle[i]) begin
        cand_vld = 1'b1;
        cand     = PW'(i);
      end
    end
  end

  // Priority grant: port s takes the k-th FIFO entry, k = requesters below it.
  always_comb begin
    alloc_gnt = '0;
    alloc_pr  = '0;
    k         = '0;
    ngnt      = '0;
`ifdef PR_FREE_LIST_BYPASS_EN
    byp       = 1'b0;
`endif
    if (!rst) begin
      for (int s = 0; s < NUM_SICS; s++) begin
        if (alloc_req[s]) begin
          if (k < count_q) begin
            alloc_gnt[s] = 1'b1;
            alloc_pr[s]  = fifo_q[wrap(CW'(head_q) + k)];
            ngnt         = ngnt + ONE;
          end
`ifdef PR_FREE_LIST_BYPASS_EN
          else if (count_q == '0 && cand_vld && !byp) begin
            alloc_gnt[s] = 1'b1;
            alloc_pr[s]  = cand;
            byp          = 1'b1;
          end
`endif
          k = k + ONE;
        end
      end
    end
  end

  // A bypassed candidate goes straight to the requester instead of the FIFO.
`ifdef PR_FREE_LIST_BYPASS_EN
  assign push = cand_vld && !byp;
`else
  assign push = cand_vld;
`endif

  // Pointer, occupancy and quarantine next state.
  always_comb begin
    head_d  = wrap(CW'(head_q) + ngnt);
    tail_d  = tail_q;
    count_d = count_q - ngnt;
    pend_d  = pend_q;
    if (push) begin
      tail_d  = wrap(CW'(tail_q) + ONE);
      count_d = count_d + ONE;
    end
    if (cand_vld) begin
      pend_d[cand] = 1'b0;
    end
    if (rel_valid && rel_pr >= ARCH) begin
      pend_d[rel_pr] = 1'b1;
    end
  end

  // State registers; reset refills the FIFO with every non-reserved PR.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= DEPTH;
      pend_q  <= '0;
      for (int i = 0; i < D; i++) begin
        fifo_q[i] <= PW'(NUM_ARCH_REGS + i);
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      if (push) begin
        fifo_q[tail_q] <= cand;
      end
    end
  end

endmodule
